// File: rtl/dec_tree_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dec_tree_pkg : shared constants and helpers for the decoder tree
// Rev 1.0
// ------------------------------------------------------------------
package dec_tree_pkg;

  localparam int MAX_SEL_W = 8;

  // Width of the partial one-hot held by tree level k.
  function automatic int stage_w(input int k);
    return 2 ** (k + 1);
  endfunction

  function automatic logic inactive_lvl(input int act_low);
    return (act_low != 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_tree_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// dec_tree_stage : one registered 1-to-2 expansion level of the tree
// Rev 1.0
// ------------------------------------------------------------------
module dec_tree_stage
  import dec_tree_pkg::*;
#(
  parameter  int SEL_W = 3,
  parameter  int K     = 0,
  localparam int DW    = stage_w(K),
  localparam int REM_W = (SEL_W - 1 - K > 0) ? (SEL_W - 1 - K) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 v_i,
  input  logic [2**K-1:0]      dec_i,
  input  logic [SEL_W-K-1:0]   sel_i,
  input  logic                 err_i,
  output logic                 rdy_o,
  input  logic                 rdy_i,
  output logic                 v_o,
  output logic [DW-1:0]        dec_o,
  output logic [REM_W-1:0]     rem_o,
  output logic                 err_o
);

  logic             v_q;
  logic             err_q;
  logic [DW-1:0]    dec_q;
  logic [DW-1:0]    dec_d;
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_d;
  logic             w_b;

  assign w_b = sel_i[SEL_W-K-1];

  always_comb begin
    dec_d = '0;
    for (int j = 0; j < 2**K; j++) begin
      dec_d[2*j+1] = dec_i[j] & w_b;
      dec_d[2*j]   = dec_i[j] & ~w_b;
    end
  end

  // The last level has no select bits left to forward.
  if (SEL_W - 1 - K > 0) begin : g_rem
    assign rem_d = sel_i[REM_W-1:0];
  end else begin : g_no_rem
    assign rem_d = '0;
  end

  assign rdy_o = ~v_q | rdy_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      dec_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else if (rdy_o) begin
      v_q   <= v_i;
      dec_q <= dec_d;
      rem_q <= rem_d;
      err_q <= err_i;
    end
  end

  assign v_o   = v_q;
  assign dec_o = dec_q;
  assign rem_o = rem_q;
  assign err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/dec_tree_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// dec_tree_pipe : pipelined N-to-2^N one-hot decoder tree with handshake
// Rev 1.0
// ------------------------------------------------------------------
module dec_tree_pipe
  import dec_tree_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 2**SEL_W,
  parameter int ACT_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_dec,
  output logic               out_err
);

  localparam logic [NUM_OUT-1:0] INACTIVE_WORD = {NUM_OUT{inactive_lvl(ACT_LOW)}};

  logic                  w_err0;
  logic                  w_dec0;
  logic                  w_v_last;
  logic                  w_err_last;
  logic [2**SEL_W-1:0]   w_dec_last;
  logic [NUM_OUT-1:0]    w_dec_used;

  // Out-of-range codes still travel as tokens, just with no output bit set.
  assign w_err0 = in_en & ({1'b0, in_sel} >= (SEL_W+1)'(NUM_OUT));
  assign w_dec0 = in_en & ~w_err0;

  for (genvar k = 0; k < SEL_W; k++) begin : g_stage
    localparam int DW = stage_w(k);
    localparam int RW = (SEL_W - 1 - k > 0) ? (SEL_W - 1 - k) : 1;

    logic               v_in;
    logic               err_in;
    logic [2**k-1:0]    dec_in;
    logic [SEL_W-k-1:0] sel_in;
    logic               rdy_nx;
    logic               rdy_o;
    logic               v_o;
    logic               err_o;
    logic [DW-1:0]      dec_o;
    logic [RW-1:0]      rem_o;

    if (k == 0) begin : g_head
      assign v_in   = in_valid;
      assign dec_in = w_dec0;
      assign sel_in = in_sel;
      assign err_in = w_err0;
    end else begin : g_body
      assign v_in   = g_stage[k-1].v_o;
      assign dec_in = g_stage[k-1].dec_o;
      assign sel_in = g_stage[k-1].rem_o;
      assign err_in = g_stage[k-1].err_o;
    end

    if (k == SEL_W - 1) begin : g_tail
      assign rdy_nx = out_ready;
    end else begin : g_mid
      assign rdy_nx = g_stage[k+1].rdy_o;
    end

    dec_tree_stage #(
      .SEL_W (SEL_W),
      .K     (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .v_i   (v_in),
      .dec_i (dec_in),
      .sel_i (sel_in),
      .err_i (err_in),
      .rdy_o (rdy_o),
      .rdy_i (rdy_nx),
      .v_o   (v_o),
      .dec_o (dec_o),
      .rem_o (rem_o),
      .err_o (err_o)
    );
  end

  assign in_ready   = g_stage[0].rdy_o;
  assign w_v_last   = g_stage[SEL_W-1].v_o;
  assign w_err_last = g_stage[SEL_W-1].err_o;
  assign w_dec_last = g_stage[SEL_W-1].dec_o;
  assign w_dec_used = w_dec_last[NUM_OUT-1:0];

  assign out_valid = w_v_last;
  assign out_err   = w_v_last & w_err_last;
  assign out_dec   = !w_v_last      ? INACTIVE_WORD :
                     (ACT_LOW != 0) ? ~w_dec_used   : w_dec_used;

endmodule
`default_nettype wire

// File: tb/tb_dec_tree_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dec_tree_pipe : four decoder configurations on one shared stream
// Rev 1.0
// ------------------------------------------------------------------
module tb_dec_tree_pipe;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_en     = 1'b0;
  logic       out_ready = 1'b1;
  logic [2:0] in_sel    = '0;

  always #5 clk = ~clk;

  logic ir_a, ov_a, oe_a; logic [7:0] od_a;
  logic ir_b, ov_b, oe_b; logic [5:0] od_b;
  logic ir_c, ov_c, oe_c; logic [3:0] od_c;
  logic ir_d, ov_d, oe_d; logic [1:0] od_d;

  dec_tree_pipe #(.SEL_W(3), .NUM_OUT(8), .ACT_LOW(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in_sel(in_sel),
    .in_en(in_en), .out_valid(ov_a), .out_ready(out_ready), .out_dec(od_a), .out_err(oe_a));
  dec_tree_pipe #(.SEL_W(3), .NUM_OUT(6), .ACT_LOW(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in_sel(in_sel),
    .in_en(in_en), .out_valid(ov_b), .out_ready(out_ready), .out_dec(od_b), .out_err(oe_b));
  dec_tree_pipe #(.SEL_W(2), .NUM_OUT(4), .ACT_LOW(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .in_sel(in_sel[1:0]),
    .in_en(in_en), .out_valid(ov_c), .out_ready(out_ready), .out_dec(od_c), .out_err(oe_c));
  dec_tree_pipe #(.SEL_W(1), .NUM_OUT(2), .ACT_LOW(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_d), .in_sel(in_sel[0:0]),
    .in_en(in_en), .out_valid(ov_d), .out_ready(out_ready), .out_dec(od_d), .out_err(oe_d));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: per-configuration FIFO of expected words, tagged with accept cycle.
  logic [7:0] q_word [4][16];
  logic       q_err  [4][16];
  int         q_acc  [4][16];
  int         hd [4];
  int         tl [4];
  int         cyc        = 0;
  int         last_stall = -1;
  bit         armed      = 1'b0;

  task automatic mon(input int d, input int w, input int n, input int al,
                     input logic ir, input logic ov, input logic [7:0] od, input logic oe);
    int         cnt;
    int         s;
    int         h;
    logic [7:0] mask;
    logic [7:0] word;
    logic       e;
    string      p;
    cnt  = tl[d] - hd[d];
    h    = hd[d] % 16;
    mask = 8'((9'd1 << n) - 9'd1);
    p    = $sformatf("cfg%0d", d);
    if (armed) begin
      chk({p, ".in_ready"}, 32'(ir), 32'(!(out_ready == 1'b0 && cnt == w)));
      if (cnt == 0) chk({p, ".idle_valid"}, 32'(ov), 32'd0);
      if (ov && cnt > 0) begin
        chk({p, ".dec"}, 32'(od), 32'(q_word[d][h]));
        chk({p, ".err"}, 32'(oe), 32'(q_err[d][h]));
        if (q_acc[d][h] > last_stall) chk({p, ".latency"}, 32'(cyc - q_acc[d][h]), 32'(w));
      end else if (!ov) begin
        chk({p, ".idle_dec"}, 32'(od), (al != 0) ? 32'(mask) : 32'd0);
        chk({p, ".idle_err"}, 32'(oe), 32'd0);
        if (cnt > 0 && q_acc[d][h] > last_stall && cyc - q_acc[d][h] >= w)
          chk({p, ".late"}, 32'(ov), 32'd1);
      end
    end
    if (!rst_n) begin
      hd[d] = 0;
      tl[d] = 0;
    end else if (armed) begin
      if (ov && out_ready && cnt > 0) hd[d]++;
      if (in_valid && ir) begin
        s    = int'(in_sel) % (1 << w);
        e    = in_en && (s >= n);
        word = (in_en && !e) ? 8'(9'd1 << s) : 8'd0;
        if (al != 0) word = ~word & mask;
        q_word[d][tl[d] % 16] = word;
        q_err [d][tl[d] % 16] = e;
        q_acc [d][tl[d] % 16] = cyc;
        tl[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 3, 8, 0, ir_a, ov_a, od_a, oe_a);
    mon(1, 3, 6, 0, ir_b, ov_b, {2'b0, od_b}, oe_b);
    mon(2, 2, 4, 1, ir_c, ov_c, {4'b0, od_c}, oe_c);
    mon(3, 1, 2, 0, ir_d, ov_d, {6'b0, od_d}, oe_d);
    if (armed && rst_n && !out_ready) last_stall = cyc;
    if (!rst_n) armed = 1'b1;
    cyc++;
  end

  task automatic step(input logic v, input logic [2:0] s, input logic e, input logic r);
    in_valid  = v;
    in_sel    = s;
    in_en     = e;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  int idx;
  int stall;
  bit seen;

  initial begin
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("reset.in_ready", 32'(ir_a), 32'd1);
    chk("reset.out_valid", 32'(ov_a), 32'd0);
    chk("reset.out_dec", 32'(od_a), 32'd0);
    chk("reset.out_err", 32'(oe_a), 32'd0);
    chk("reset.act_low_dec", 32'(od_c), 32'hF);

    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b1, 1'b1);
    idle(4);
    step(1'b1, 3'd5, 1'b0, 1'b1);
    idle(4);
    step(1'b1, 3'd6, 1'b1, 1'b1);
    step(1'b1, 3'd7, 1'b1, 1'b1);
    step(1'b1, 3'd5, 1'b1, 1'b1);
    idle(4);

    idx = 0; stall = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ov_a) seen = 1'b1;
      in_valid  = (idx < 4);
      in_sel    = 3'(idx + 1);
      in_en     = 1'b1;
      out_ready = !(seen && stall < 5);
      if (!out_ready) stall++;
      @(negedge clk);
      if (in_valid && ir_a) idx++;
      @(posedge clk);
      #1;
      if (idx >= 4 && stall >= 5 && !ov_a) break;
    end
    chk("bp.all_accepted", 32'(idx), 32'd4);
    idle(2);

    step(1'b1, 3'd1, 1'b1, 1'b1);
    step(1'b1, 3'd2, 1'b1, 1'b1);
    step(1'b1, 3'd3, 1'b1, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    chk("midrst.in_ready", 32'(ir_a), 32'd1);
    chk("midrst.out_valid", 32'(ov_a), 32'd0);
    idle(3);

    step(1'b1, 3'd2, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    chk("pol.sel2", 32'(od_c), 32'hB);
    idle(3);
    chk("pol.idle", 32'(od_c), 32'hF);
    step(1'b1, 3'd1, 1'b1, 1'b1);
    chk("w1.sel1", 32'(od_d), 32'h2);
    idle(4);

    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 7) != 0,
           $urandom_range(0, 9) < 7);
    end
    rst_n = 1'b1;
    idle(10);
    for (int d = 0; d < 4; d++) chk($sformatf("drain.cfg%0d", d), 32'(tl[d] - hd[d]), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
